axi_grid_rsp_sched: RTL

- Packet scheduler for the response side of a grid master network interface.
- Shares one grid injection link between two AXI response sources: B responses (one beat) and R bursts (multi-beat).
- Wraps each response in a packet: one header flit carrying destination, source and channel, then the body beats.
- Packets are never interleaved; arbitration happens only at packet boundaries.
- Sits between the AXI-side response capture and the local router input port.

---
 rtl/axi_default_param_pkg.sv | 46 ++++
 rtl/axi_grid_rsp_sched_rr_arb2.sv | 46 ++++
 rtl/axi_grid_rsp_sched.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/axi_default_param_pkg.sv
// Shared grid NI types: node ids, AXI B/R payloads, link flit, header and scheduler states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Header layout is {chan, src, dst} with chan in the MSB; the flit must be at least as wide
// as the header and both payload types.
package axi_default_param_pkg;

  localparam int unsigned GRID_ID_W  = 4;
  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_DATA_W = 32;

  typedef logic [GRID_ID_W-1:0] grid_id_t;

  typedef enum logic {
    CH_B = 1'b0,
    CH_R = 1'b1
  } chan_e;

  typedef struct packed {
    chan_e    chan;
    grid_id_t src;
    grid_id_t dst;
  } grid_hdr_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } grid_b_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
  } grid_r_chan_t;

  localparam int unsigned GRID_FLIT_W = 40;
  typedef logic [GRID_FLIT_W-1:0] grid_flit_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HDR    = 2'd1,
    ST_B_BODY = 2'd2,
    ST_R_BODY = 2'd3
  } sched_state_e;

endpackage

// File: rtl/axi_grid_rsp_sched_rr_arb2.sv
// Two-requester round-robin arbiter with lock; requester 0 may get strict priority.
// Latency: combinational grant; the last-grant pointer updates on the granting edge.
// Backpressure: lock_i high suppresses all grants and freezes the pointer.
// Ports: clk_i/arst_i clock and async active-high reset, req_i[1:0] requests,
//        lock_i grant inhibit, gnt_o[1:0] one-hot grant.
// Option macro: AXI_GRID_RSP_SCHED_B_PRIO_EN gives requester 0 strict priority.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic [1:0] req_i,
  input  logic       lock_i,
  output logic [1:0] gnt_o
);

  // 1 means requester 1 won last; reset value favours requester 0 on the first tie.
  logic last_q;

  always_comb begin
    gnt_o = 2'b00;
    if (!lock_i) begin
`ifdef AXI_GRID_RSP_SCHED_B_PRIO_EN
      if (req_i[0]) begin
        gnt_o = 2'b01;
      end else if (req_i[1]) begin
        gnt_o = 2'b10;
      end
`else
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
`endif
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      last_q <= 1'b1;
    end else if (|gnt_o) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/axi_grid_rsp_sched.sv
// Packetises AXI B responses and R bursts onto one grid injection link, never interleaving packets.
// Latency: source valid in IDLE -> header valid next cycle; one idle bubble after each tail flit.
// Backpressure: flit_ready_i low holds state and flit; body source ready follows flit_ready_i.
// Ports: clk_i/arst_i clock and async active-high reset; b_* B response source; r_* R beat
//        source (r_dst_i sampled at grant only); flit_* link output with head/tail marks;
//        err_o sticky burst-guard flag (R burst exceeded MAX_R_BEATS without r_last_i).
// Option macro: AXI_GRID_RSP_SCHED_B_PRIO_EN gives B strict priority at packet boundaries.
module axi_grid_rsp_sched #(
  parameter type         grid_id_t     = axi_default_param_pkg::grid_id_t,
  parameter type         grid_b_chan_t = axi_default_param_pkg::grid_b_chan_t,
  parameter type         grid_r_chan_t = axi_default_param_pkg::grid_r_chan_t,
  parameter type         flit_t        = axi_default_param_pkg::grid_flit_t,
  parameter int unsigned NI_ID         = 0,
  parameter int unsigned MAX_R_BEATS   = 256
) (
  input  logic         clk_i,
  input  logic         arst_i,
  input  grid_b_chan_t b_i,
  input  grid_id_t     b_dst_i,
  input  logic         b_valid_i,
  output logic         b_ready_o,
  input  grid_r_chan_t r_i,
  input  grid_id_t     r_dst_i,
  input  logic         r_last_i,
  input  logic         r_valid_i,
  output logic         r_ready_o,
  output flit_t        flit_o,
  output logic         flit_head_o,
  output logic         flit_tail_o,
  output logic         flit_valid_o,
  input  logic         flit_ready_i,
  output logic         err_o
);

  import axi_default_param_pkg::*;

  localparam int unsigned ID_W   = $bits(grid_id_t);
  localparam int unsigned HDR_W  = 1 + 2 * ID_W;
  localparam int unsigned B_W    = $bits(grid_b_chan_t);
  localparam int unsigned R_W    = $bits(grid_r_chan_t);
  localparam int unsigned FLIT_W = $bits(flit_t);
  localparam int unsigned CNT_W  = (MAX_R_BEATS > 1) ? $clog2(MAX_R_BEATS) : 1;

  localparam grid_id_t         OWN_ID   = grid_id_t'(NI_ID);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_R_BEATS - 1);

  if (FLIT_W < HDR_W || FLIT_W < B_W || FLIT_W < R_W) begin : g_flit_too_narrow
    $error("flit_t is narrower than the header or a payload type");
  end

  sched_state_e     state_q;
  chan_e            chan_q;
  logic [HDR_W-1:0] hdr_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic             err_q;

  logic [1:0]        gnt;
  logic              r_xfer;
  logic              beat_at_max;
  logic [B_W-1:0]    b_bits;
  logic [R_W-1:0]    r_bits;
  logic [FLIT_W-1:0] flit_d;

  assign b_bits = b_i;
  assign r_bits = r_i;

  // Arbitration only while idle, so a packet in flight can never be preempted.
  rr_arb2 u_arb (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .req_i  ({r_valid_i, b_valid_i}),
    .lock_i (state_q != ST_IDLE),
    .gnt_o  (gnt)
  );

  assign r_xfer      = (state_q == ST_R_BODY) && r_valid_i && flit_ready_i;
  assign beat_at_max = (beat_cnt_q == CNT_LAST);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= ST_IDLE;
      chan_q     <= CH_B;
      hdr_q      <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt[0]) begin
            chan_q  <= CH_B;
            hdr_q   <= {CH_B, OWN_ID, b_dst_i};
            state_q <= ST_HDR;
          end else if (gnt[1]) begin
            chan_q  <= CH_R;
            hdr_q   <= {CH_R, OWN_ID, r_dst_i};
            state_q <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (flit_ready_i) begin
            state_q <= (chan_q == CH_B) ? ST_B_BODY : ST_R_BODY;
          end
        end
        ST_B_BODY: begin
          if (b_valid_i && flit_ready_i) begin
            state_q <= ST_IDLE;
          end
        end
        ST_R_BODY: begin
          if (r_xfer) begin
            if (r_last_i) begin
              state_q    <= ST_IDLE;
              beat_cnt_q <= '0;
            end else if (beat_at_max) begin
              // Overlong burst: close this packet here; the rest of the burst
              // re-arbitrates and goes out under a fresh header.
              state_q    <= ST_IDLE;
              beat_cnt_q <= '0;
              err_q      <= 1'b1;
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output decode is purely from state plus the active body source, so an async
  // reset drops every output in the same cycle.
  always_comb begin
    flit_d       = '0;
    flit_valid_o = 1'b0;
    flit_head_o  = 1'b0;
    flit_tail_o  = 1'b0;
    b_ready_o    = 1'b0;
    r_ready_o    = 1'b0;
    case (state_q)
      ST_HDR: begin
        flit_d       = FLIT_W'(hdr_q);
        flit_valid_o = 1'b1;
        flit_head_o  = 1'b1;
      end
      ST_B_BODY: begin
        flit_d       = FLIT_W'(b_bits);
        flit_valid_o = b_valid_i;
        b_ready_o    = flit_ready_i;
        flit_tail_o  = 1'b1;
      end
      ST_R_BODY: begin
        flit_d       = FLIT_W'(r_bits);
        flit_valid_o = r_valid_i;
        r_ready_o    = flit_ready_i;
        flit_tail_o  = r_last_i | beat_at_max;
      end
      default: ;
    endcase
  end

  assign flit_o = flit_t'(flit_d);
  assign err_o  = err_q;

endmodule
